// File: rtl/xts_sector_ctrl_if.sv
// rtl/xts_sector_ctrl_if.sv - host stream, command and core request signals of xts_sector_ctrl
interface xts_sector_ctrl_if #(
    parameter int BLK_CNT_W = 5
);
    logic                 i_start;
    logic                 i_enc;
    logic [BLK_CNT_W-1:0] i_num_blocks;
    logic [255:0]         i_key1;
    logic [255:0]         i_key2;
    logic [127:0]         i_tweak;
    logic [127:0]         i_data;
    logic                 i_data_valid;
    logic                 o_data_ready;
    logic [127:0]         o_data;
    logic                 o_data_valid;
    logic                 i_data_ready;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_core_start;
    logic                 o_core_key_valid;
    logic                 o_core_en_de;
    logic [255:0]         o_core_key;
    logic [127:0]         o_core_data;
    logic [127:0]         i_core_data;
    logic                 i_core_data_valid;

    modport slave (
        input  i_start, i_enc, i_num_blocks, i_key1, i_key2, i_tweak,
        input  i_data, i_data_valid, i_data_ready, i_core_data, i_core_data_valid,
        output o_data_ready, o_data, o_data_valid, o_busy, o_done,
        output o_core_start, o_core_key_valid, o_core_en_de, o_core_key, o_core_data
    );

    modport master (
        output i_start, i_enc, i_num_blocks, i_key1, i_key2, i_tweak,
        output i_data, i_data_valid, i_data_ready, i_core_data, i_core_data_valid,
        input  o_data_ready, o_data, o_data_valid, o_busy, o_done,
        input  o_core_start, o_core_key_valid, o_core_en_de, o_core_key, o_core_data
    );
endinterface

// File: rtl/xts_sector_ctrl.sv
// rtl/xts_sector_ctrl.sv - XTS data-unit sequencer driving a single-block Serpent core
// Define XTS_TWEAK_ENCRYPT_EN to derive the initial tweak as E_key2(i_tweak) on the core.
module xts_sector_ctrl #(
    parameter int BLK_CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    xts_sector_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, TWK_REQ, TWK_WAIT, IN_WAIT, BLK_REQ, BLK_WAIT, OUT_HOLD, DONE
    } state_t;

    state_t               state;
    logic                 enc_q;
    logic [BLK_CNT_W-1:0] num_q;
    logic [BLK_CNT_W-1:0] cnt_q;
    logic [BLK_CNT_W-1:0] cnt_inc;
    logic [127:0]         twk_q;

    assign cnt_inc = cnt_q + {{(BLK_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [127:0] gf_double(input logic [127:0] t);
        return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
    endfunction

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state                 <= IDLE;
            enc_q                 <= 1'b0;
            num_q                 <= '0;
            cnt_q                 <= '0;
            twk_q                 <= '0;
            bus.o_data_ready      <= 1'b0;
            bus.o_data            <= '0;
            bus.o_data_valid      <= 1'b0;
            bus.o_busy            <= 1'b0;
            bus.o_done            <= 1'b0;
            bus.o_core_start      <= 1'b0;
            bus.o_core_key_valid  <= 1'b0;
            bus.o_core_en_de      <= 1'b0;
            bus.o_core_key        <= '0;
            bus.o_core_data       <= '0;
        end else begin
            bus.o_core_start     <= 1'b0;
            bus.o_core_key_valid <= 1'b0;
            bus.o_done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        enc_q      <= bus.i_enc;
                        num_q      <= bus.i_num_blocks;
                        cnt_q      <= '0;
                        twk_q      <= bus.i_tweak;
                        bus.o_busy <= 1'b1;
                        if (bus.i_num_blocks == '0) begin
                            state <= DONE;
                        end else begin
`ifdef XTS_TWEAK_ENCRYPT_EN
                            state <= TWK_REQ;
`else
                            state            <= IN_WAIT;
                            bus.o_data_ready <= 1'b1;
`endif
                        end
                    end
                end
                // Tweak pass: encrypt the sector number under key2 to obtain T0.
                TWK_REQ: begin
                    bus.o_core_start     <= 1'b1;
                    bus.o_core_key_valid <= 1'b1;
                    bus.o_core_key       <= bus.i_key2;
                    bus.o_core_en_de     <= 1'b1;
                    bus.o_core_data      <= twk_q;
                    state                <= TWK_WAIT;
                end
                TWK_WAIT: begin
                    if (bus.i_core_data_valid) begin
                        twk_q            <= bus.i_core_data;
                        bus.o_data_ready <= 1'b1;
                        state            <= IN_WAIT;
                    end
                end
                // Pre-whitened block goes straight into the core data register; no request is in flight here.
                IN_WAIT: begin
                    if (bus.i_data_valid) begin
                        bus.o_core_data  <= bus.i_data ^ twk_q;
                        bus.o_data_ready <= 1'b0;
                        state            <= BLK_REQ;
                    end
                end
                BLK_REQ: begin
                    bus.o_core_start     <= 1'b1;
                    bus.o_core_key_valid <= 1'b1;
                    bus.o_core_key       <= bus.i_key1;
                    bus.o_core_en_de     <= enc_q;
                    state                <= BLK_WAIT;
                end
                BLK_WAIT: begin
                    if (bus.i_core_data_valid) begin
                        bus.o_data       <= bus.i_core_data ^ twk_q;
                        bus.o_data_valid <= 1'b1;
                        state            <= OUT_HOLD;
                    end
                end
                OUT_HOLD: begin
                    if (bus.i_data_ready) begin
                        bus.o_data_valid <= 1'b0;
                        twk_q            <= gf_double(twk_q);
                        cnt_q            <= cnt_inc;
                        if (cnt_inc == num_q) begin
                            state <= DONE;
                        end else begin
                            bus.o_data_ready <= 1'b1;
                            state            <= IN_WAIT;
                        end
                    end
                end
                DONE: begin
                    bus.o_done <= 1'b1;
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xts_sector_ctrl.sv
// tb/tb_xts_sector_ctrl.sv - self-checking bench for xts_sector_ctrl with a behavioural XOR core
// Honours XTS_TWEAK_ENCRYPT_EN the same way the design does.
module tb_xts_sector_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xts_sector_ctrl_if #(.BLK_CNT_W(W)) bus ();
    xts_sector_ctrl #(.BLK_CNT_W(W)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

    typedef struct {
        logic [127:0] data;
        logic [255:0] key;
        logic         en;
    } core_req_t;

    typedef struct {
        logic         enc;
        int           nb;
        logic [127:0] tw;
        logic [255:0] k1;
        logic [127:0] b0, b1;
        logic [127:0] ec0, ec1, eo0, eo1;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    core_req_t    core_q[$];
    core_req_t    exp_core_q[$];
    logic [127:0] out_q[$];
    logic [127:0] exp_out_q[$];
    logic [127:0] blk_q[$];
    int           core_lat  = 40;
    bit           core_busy = 0;
    int           stab_err  = 0;
    int           gap_err   = 0;

    // Stand-in core: encrypt XORs the low key word, decrypt the high one, so en_de is observable.
    function automatic logic [127:0] core_f(input logic [255:0] k, input logic e, input logic [127:0] d);
        return e ? (d ^ k[127:0]) : (d ^ k[255:128]);
    endfunction

    function automatic logic [127:0] dbl(input logic [127:0] t);
        logic [127:0] r;
        r = t << 1;
        if (t[127]) r = r ^ 128'd135;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : core_model
        core_req_t cur;
        int cnt;
        int cyc;
        int last_vs;
        cnt = 0; cyc = 0; last_vs = -10;
        bus.i_core_data = '0;
        bus.i_core_data_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            bus.i_core_data_valid = 1'b0;
            if (!rstn) begin
                core_busy = 0;
                continue;
            end
            if (core_busy) begin
                if (bus.o_core_data !== cur.data || bus.o_core_key !== cur.key ||
                    bus.o_core_en_de !== cur.en || bus.o_core_start) stab_err++;
                cnt--;
                if (cnt == 0) begin
                    bus.i_core_data = core_f(cur.key, cur.en, cur.data);
                    bus.i_core_data_valid = 1'b1;
                    core_busy = 0;
                    last_vs = cyc + 1;
                end
            end else if (bus.o_core_start) begin
                if (!bus.o_core_key_valid) stab_err++;
                if (cyc - last_vs < 2) gap_err++;
                cur.data = bus.o_core_data;
                cur.key  = bus.o_core_key;
                cur.en   = bus.o_core_en_de;
                core_q.push_back(cur);
                cnt = core_lat;
                core_busy = 1;
            end
        end
    end

    task automatic model(input logic enc, input logic [127:0] tw);
        logic [127:0] t;
        core_req_t r;
        exp_out_q.delete();
        exp_core_q.delete();
`ifdef XTS_TWEAK_ENCRYPT_EN
        r.data = tw; r.key = bus.i_key2; r.en = 1'b1;
        exp_core_q.push_back(r);
        t = core_f(bus.i_key2, 1'b1, tw);
`else
        t = tw;
`endif
        foreach (blk_q[i]) begin
            r.data = blk_q[i] ^ t; r.key = bus.i_key1; r.en = enc;
            exp_core_q.push_back(r);
            exp_out_q.push_back(core_f(bus.i_key1, enc, blk_q[i] ^ t) ^ t);
            t = dbl(t);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nout"}, out_q.size(), exp_out_q.size());
        check({tag, "_ncore"}, core_q.size(), exp_core_q.size());
        for (int i = 0; i < out_q.size() && i < exp_out_q.size(); i++)
            check({tag, "_out"}, out_q[i], exp_out_q[i]);
        for (int i = 0; i < core_q.size() && i < exp_core_q.size(); i++) begin
            check({tag, "_cdata"}, core_q[i].data, exp_core_q[i].data);
            check({tag, "_ckey"}, core_q[i].key, exp_core_q[i].key);
            check({tag, "_cen"}, core_q[i].en, exp_core_q[i].en);
        end
    endtask

    task automatic send_cmd(input logic enc, input int nb, input logic [127:0] tw);
        core_q.delete();
        out_q.delete();
        bus.i_enc = enc;
        bus.i_num_blocks = W'(nb);
        bus.i_tweak = tw;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("busy_after_cmd", bus.o_busy, 1);
    endtask

    task automatic run_loop(input int bi0, input bit stall, output int last_out, output int done_c);
        int bi;
        bit in_hs, out_hs;
        bi = bi0; last_out = -1; done_c = -1;
        for (int c = 1; c <= 3000; c++) begin
            bus.i_data_valid = (bi < blk_q.size()) && (!stall || $urandom_range(0, 3) != 0);
            bus.i_data       = (bi < blk_q.size()) ? blk_q[bi] : '0;
            bus.i_data_ready = !stall || ($urandom_range(0, 2) != 0);
            in_hs  = bus.i_data_valid && bus.o_data_ready;
            out_hs = bus.o_data_valid && bus.i_data_ready;
            if (out_hs) out_q.push_back(bus.o_data);
            @(posedge clk); #1;
            if (in_hs) bi++;
            if (out_hs) last_out = c;
            if (bus.o_done) begin
                done_c = c;
                break;
            end
        end
        bus.i_data_valid = 1'b0;
        bus.i_data_ready = 1'b0;
        check("done_seen", done_c > 0, 1);
    endtask

    task automatic run_sector(input logic enc, input int nb, input logic [127:0] tw,
                              input bit stall, input string tag);
        int lo, dc;
        send_cmd(enc, nb, tw);
        run_loop(0, stall, lo, dc);
        model(enc, tw);
        compare_all(tag);
        if (nb > 0) check({tag, "_done_lat"}, dc, lo + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.o_data_ready, bus.o_data_valid, bus.o_busy, bus.o_done,
                               bus.o_core_start, bus.o_core_key_valid, bus.o_core_en_de}, 0);
        check({tag, "_data"}, {bus.o_data | bus.o_core_data | bus.o_core_key[127:0] | bus.o_core_key[255:128]}, 0);
    endtask

    initial begin : main
        vec_t vt[4];
        int lo, dc, bi, bad;
        bit ok, in_hs;
        logic [127:0] hold, tw;
        logic enc;
        int nb;

        vt[0] = '{1'b1, 1, 128'h1, 256'h0, 128'h0, 128'h0, 128'h1, 128'h0, 128'h0, 128'h0};
        vt[1] = '{1'b1, 2, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 256'h0, 128'h0, 128'h0,
                  128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h85, 128'h0, 128'h0};
        vt[2] = '{1'b0, 1, 128'h10, {128'h5, 128'h0}, 128'h3, 128'h0, 128'h13, 128'h0, 128'h6, 128'h0};
        vt[3] = '{1'b1, 2, 128'h1, {128'h0, 128'hF0}, 128'h0F, 128'h0F, 128'h0E, 128'h0D, 128'hFF, 128'hFF};

        bus.i_start = 0; bus.i_enc = 0; bus.i_num_blocks = '0; bus.i_key1 = '0; bus.i_key2 = '0;
        bus.i_tweak = '0; bus.i_data = '0; bus.i_data_valid = 0; bus.i_data_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

`ifndef XTS_TWEAK_ENCRYPT_EN
        foreach (vt[v]) begin
            bus.i_key1 = vt[v].k1;
            bus.i_key2 = '0;
            blk_q.delete();
            blk_q.push_back(vt[v].b0);
            if (vt[v].nb > 1) blk_q.push_back(vt[v].b1);
            send_cmd(vt[v].enc, vt[v].nb, vt[v].tw);
            run_loop(0, 0, lo, dc);
            check("tbl_done_lat", dc, lo + 1);
            check("tbl_ncore", core_q.size(), vt[v].nb);
            check("tbl_nout", out_q.size(), vt[v].nb);
            if (core_q.size() > 0) check("tbl_core0", core_q[0].data, vt[v].ec0);
            if (out_q.size() > 0) check("tbl_out0", out_q[0], vt[v].eo0);
            if (vt[v].nb > 1 && core_q.size() > 1) check("tbl_core1", core_q[1].data, vt[v].ec1);
            if (vt[v].nb > 1 && out_q.size() > 1) check("tbl_out1", out_q[1], vt[v].eo1);
        end
`else
        core_lat = 5;
        bus.i_key1 = '0;
        bus.i_key2 = {128'h0, 128'hFF};
        blk_q.delete();
        blk_q.push_back(128'h1234);
        send_cmd(1'b1, 1, 128'h0);
        run_loop(0, 0, lo, dc);
        check("twk_ncore", core_q.size(), 2);
        if (core_q.size() > 1) begin
            check("twk_req_data", core_q[0].data, 128'h0);
            check("twk_req_key", core_q[0].key, {128'h0, 128'hFF});
            check("twk_req_en", core_q[0].en, 1);
            check("twk_blk_data", core_q[1].data, 128'h1234 ^ 128'hFF);
        end
`endif

        // Empty sector: o_done on the following cycle, no core traffic.
        core_lat = 4;
        blk_q.delete();
        send_cmd(1'b1, 0, 128'h77);
        run_loop(0, 0, lo, dc);
        check("zero_done_lat", dc, 1);
        check("zero_ncore", core_q.size(), 0);

        // A second start while busy must not change the block count.
        bus.i_key1 = {rnd128(), rnd128()};
        bus.i_key2 = {rnd128(), rnd128()};
        blk_q.delete();
        blk_q.push_back(rnd128());
        blk_q.push_back(rnd128());
        tw = rnd128();
        send_cmd(1'b1, 2, tw);
        bus.i_start = 1'b1; bus.i_num_blocks = W'(5); bus.i_enc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        run_loop(0, 0, lo, dc);
        model(1'b1, tw);
        compare_all("busy_start");

        // Output backpressure for 10 cycles with the next input block already offered.
        core_lat = 3;
        blk_q.delete();
        blk_q.push_back(rnd128());
        blk_q.push_back(rnd128());
        tw = rnd128();
        send_cmd(1'b1, 2, tw);
        bi = 0; ok = 0;
        bus.i_data = blk_q[0]; bus.i_data_valid = 1'b1; bus.i_data_ready = 1'b0;
        for (int c = 0; c < 200; c++) begin
            in_hs = bus.i_data_valid && bus.o_data_ready;
            @(posedge clk); #1;
            if (in_hs) begin
                bi = 1;
                bus.i_data = blk_q[1];
            end
            if (bus.o_data_valid) begin
                ok = 1;
                break;
            end
        end
        check("bp_first_valid", ok, 1);
        hold = bus.o_data; bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.o_data !== hold || !bus.o_data_valid || bus.o_data_ready || bus.o_core_start) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_inputs_taken", bi, 1);
        run_loop(bi, 0, lo, dc);
        model(1'b1, tw);
        compare_all("bp");

        // Reset while the core is working on a block, then a clean sector.
        core_lat = 20;
        blk_q.delete();
        blk_q.push_back(rnd128());
        send_cmd(1'b0, 3, rnd128());
        bus.i_data = blk_q[0]; bus.i_data_valid = 1'b1;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (core_busy) begin
                ok = 1;
                break;
            end
        end
        check("rst_reached_blk_wait", ok, 1);
        #2 rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus.i_data_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_reset_edge");
        rstn = 1'b1;
        @(posedge clk); #1;
        core_lat = 6;
        blk_q.delete();
        for (int i = 0; i < 3; i++) blk_q.push_back(rnd128());
        run_sector(1'b0, 3, rnd128(), 1'b0, "post_reset");

        // Randomised sectors against the reference model.
        for (int s = 0; s < 25; s++) begin
            core_lat = $urandom_range(1, 12);
            enc = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 6);
            bus.i_key1 = {rnd128(), rnd128()};
            bus.i_key2 = {rnd128(), rnd128()};
            blk_q.delete();
            for (int i = 0; i < nb; i++) blk_q.push_back(rnd128());
            run_sector(enc, nb, rnd128(), 1'($urandom_range(0, 1)), "rand");
        end

        check("core_inputs_stable", stab_err, 0);
        check("core_request_gap", gap_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xts_sector_ctrl.md
# xts_sector_ctrl

Initiator-side sequencer that drives `serpent_top` as an XTS-AES-style (IEEE 1619 structure, Serpent cipher) data-unit engine. It accepts a sector command and a stream of 128-bit blocks, and issues one core request per block to `serpent_top`. It applies the XTS pre- and post-whitening XOR with the running tweak and advances the tweak by GF(2^128) doubling. It sits between the host/DMA streaming interface and `serpent_top`.

## Interface
- BLK_CNT_W, 5, width of block-count field; max sector length 2^BLK_CNT_W−1 blocks
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  sector command strobe, sampled only in IDLE
- i_enc  in  1  1 = encrypt, 0 = decrypt; latched at command accept
- i_num_blocks  in  BLK_CNT_W  blocks in sector; latched at command accept
- i_key1  in  256  data key; must be stable while o_busy=1
- i_key2  in  256  tweak key; must be stable while o_busy=1
- i_tweak  in  128  sector tweak input; latched at command accept
- i_data  in  128  input block
- i_data_valid  in  1  input block valid
- o_data_ready  out  1  input block accepted when i_data_valid & o_data_ready
- o_data  out  128  output block
- o_data_valid  out  1  output block valid; held until accepted
- i_data_ready  in  1  downstream ready
- o_busy  out  1  high from command accept until the o_done cycle
- o_done  out  1  one-cycle pulse at end of sector
- o_core_start, o_core_key_valid  out  1  one-cycle request pulse to the core
- o_core_en_de  out  1  core mode, 1 = encrypt
- o_core_key  out  256  core key
- o_core_data  out  128  core input block
- i_core_data  in  128  core output block
- i_core_data_valid  in  1  core done

## Operation
- The tweak T is a 128-bit integer: bit 127 is the MSB.
- Doubling: T' = {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0).
- FSM states: IDLE, TWK_REQ, TWK_WAIT, IN_WAIT, BLK_REQ, BLK_WAIT, OUT_HOLD, DONE.
- IDLE → (i_start):
  - latch i_enc, i_num_blocks and i_tweak; clear the block counter.
  - If i_num_blocks=0, go to DONE. Otherwise go to TWK_REQ.
- TWK_REQ:
  - pulse o_core_start and o_core_key_valid.
  - drive o_core_key=i_key2, o_core_en_de=1, o_core_data=latched tweak.
  - go to TWK_WAIT.
- TWK_WAIT:
  - on i_core_data_valid, T ← i_core_data.
  - go to IN_WAIT.
- IN_WAIT:
  - o_data_ready=1.
  - on input handshake, X ← i_data ^ T; go to BLK_REQ.
- BLK_REQ:
  - pulse the request with o_core_key=i_key1, o_core_en_de=latched i_enc, o_core_data=X.
  - go to BLK_WAIT.
- BLK_WAIT:
  - on i_core_data_valid, o_data ← i_core_data ^ T; go to OUT_HOLD.
- OUT_HOLD:
  - o_data_valid=1.
  - on output handshake: T ← T'; counter += 1.
  - If the counter reaches num_blocks, go to DONE. Otherwise go to IN_WAIT.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Core inputs hold steady from the request cycle until i_core_data_valid is sampled:
  - o_core_key, o_core_en_de and o_core_data.
  - Reason: the core muxes its output on en_de.
- The next request is issued no earlier than 2 cycles after the previous i_core_data_valid, so the core is back in IDLE first.
- i_core_data_valid outside TWK_WAIT/BLK_WAIT is ignored.
- i_start while o_busy=1 is ignored.
- Only one block is in flight. Input is not accepted in any state except IN_WAIT.

## Timing
- Reset values: every output is 0. The FSM resets to IDLE and T resets to 0.
- Reset mid-operation:
  - immediately drops o_core_start, o_data_valid and o_busy.
  - In-flight core results are discarded. After reset the core must be allowed to finish or be reset together with this block.
- All outputs are registered.
- o_busy rises the cycle after i_start is accepted.
- Request latency: o_core_start asserts 1 cycle after entering TWK_REQ or BLK_REQ.
- Per-block overhead:
  - input handshake → o_core_start: 1 cycle.
  - i_core_data_valid → o_data_valid: 1 cycle.
  - output handshake → o_data_ready: 1 cycle.
- o_data and o_data_valid are stable while i_data_ready=0.
- If output and input are both ready, one block costs the core latency + 3 cycles.
- Counter arithmetic is BLK_CNT_W bits with no wrap. The termination compare is exact equality.

## Configuration
- XTS_TWEAK_ENCRYPT_EN defined:
  - i_tweak is the sector number.
  - The initial tweak is E_key2(i_tweak), computed by the TWK_REQ/TWK_WAIT core pass.
- Undefined:
  - i_tweak is the precomputed T0 and is loaded directly into T.
  - IDLE goes straight to IN_WAIT, and the TWK states are never entered.
  - i_key2 is unused.

## Test plan
- Core model (output = data ^ key[127:0] after 40 cycles), macro undefined, i_tweak=1, key1 low word=0, 1 block of 0 → o_data=0; core saw o_core_data=1; o_done one cycle after the output handshake.
- Doubling check, macro undefined, i_tweak=128'h8000…0001, 2 blocks of 0, identity core → outputs 0 and core inputs …0001 then 128'h…0085.
- Macro defined, key2 low word=128'hFF, i_tweak=0 → first core request uses key2 with en_de=1, data=0; block-1 core input = i_data ^ 128'hFF.
- Backpressure: i_data_ready=0 for 10 cycles → o_data and o_data_valid stable; no new o_data_ready or core start until the handshake.
- i_num_blocks=0 → o_done 1 cycle after the command, no core request; i_start during busy → ignored, block count unchanged.
- i_rstn asserted during BLK_WAIT → all outputs 0 next edge; a new command afterwards completes correctly.
